// File: rtl/i4003_loader_if.sv
// Host-side word handshake for the i4003 serial loader.
// The host drives data/valid; the loader answers with ready.
interface i4003_loader_if #(
  parameter int W = 10
);
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/i4003_loader.sv
// Serial load controller driving cp/data/enable of cascaded i4003 chips.
// Optional I4003_LOADER_BLANK_EN blanks enable while a word ripples in.
module i4003_loader #(
  parameter int CHAIN_LEN   = 1,
  parameter int SETUP_CYC   = 2,
  parameter int CP_HIGH_CYC = 4,
  parameter int CP_LOW_CYC  = 4
) (
  input  logic           sysclk,
  input  logic           poc,
  i4003_loader_if.slave  ld,
  output logic           cp,
  output logic           serial_out,
  output logic           enable,
  output logic           busy,
  output logic           done
);
  localparam int W  = 10 * CHAIN_LEN;
  localparam int M1 = (SETUP_CYC > CP_HIGH_CYC) ? SETUP_CYC : CP_HIGH_CYC;
  localparam int MP = (M1 > CP_LOW_CYC) ? M1 : CP_LOW_CYC;
  localparam int PW = $clog2(MP + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CP_HI, CP_LO, DONE
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [PW-1:0]  pcnt;
  logic [BW-1:0]  bitcnt;
  logic [W-1:0]   shreg;
  logic           armed;
  logic           accept;
  logic           phase_end;

  assign accept    = ld.load_valid & ld.load_ready;
  assign phase_end = (pcnt == '0);

  function automatic logic [PW-1:0] reload(state_t s);
    case (s)
      SETUP:   reload = PW'(SETUP_CYC - 1);
      CP_HI:   reload = PW'(CP_HIGH_CYC - 1);
      CP_LO:   reload = PW'(CP_LOW_CYC - 1);
      default: reload = '0;
    endcase
  endfunction

  // armed keeps ready/enable low until the first edge after poc
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      state_q <= IDLE;
      armed   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      pcnt   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      if (state_d != state_q)
        pcnt <= reload(state_d);
      else if (!phase_end)
        pcnt <= pcnt - 1'b1;
      if (accept) begin
        shreg  <= ld.load_data;
        bitcnt <= BW'(W);
      end else if (state_q == CP_LO && phase_end) begin
        shreg  <= {shreg[W-2:0], 1'b0};
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (phase_end) state_d = CP_HI;
      CP_HI: if (phase_end) state_d = CP_LO;
      CP_LO: if (phase_end)
               state_d = (bitcnt == BW'(1)) ? DONE : SETUP;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld.load_ready = 1'b0;
    cp            = 1'b0;
    serial_out    = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        ld.load_ready = armed;
        busy          = 1'b0;
      end
      SETUP: serial_out = shreg[W-1];
      CP_HI: begin
        cp         = 1'b1;
        serial_out = shreg[W-1];
      end
      CP_LO: serial_out = shreg[W-1];
      DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

`ifdef I4003_LOADER_BLANK_EN
  logic en_q;

  always_ff @(posedge sysclk or posedge poc) begin
    if (poc)
      en_q <= 1'b0;
    else if (accept)
      en_q <= 1'b0;
    else if (state_q == DONE)
      en_q <= 1'b1;
  end

  assign enable = en_q;
`else
  assign enable = armed;
`endif
endmodule

// File: tb/tb_i4003_loader.sv
// Scoreboard bench for i4003_loader: random words, backpressure,
// cascade, mid-transfer reset and handshake corners.
module tb_i4003_loader;
  localparam int CL = 2;
  localparam int S  = 1;
  localparam int H  = 2;
  localparam int L  = 2;
  localparam int W  = 10 * CL;
  localparam int P  = S + H + L;

  logic sysclk = 1'b0;
  logic poc    = 1'b1;
  logic cp;
  logic serial_out;
  logic enable;
  logic busy;
  logic done;

  i4003_loader_if #(.W(W)) ld ();

  i4003_loader #(
    .CHAIN_LEN(CL),
    .SETUP_CYC(S),
    .CP_HIGH_CYC(H),
    .CP_LOW_CYC(L)
  ) dut (
    .sysclk(sysclk),
    .poc(poc),
    .ld(ld),
    .cp(cp),
    .serial_out(serial_out),
    .enable(enable),
    .busy(busy),
    .done(done)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [W-1:0] word;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           accs[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           rises = 0;
  int           base = 0;
  bit           armed_m = 0;
  bit           completed = 0;
  logic [W-1:0] chain = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge sysclk) begin
    cyc++;
    armed_m = !poc;
  end

  // behavioural i4003 chain: every cp rise shifts serial data in
  always @(posedge cp) begin
    chain = {chain[W-2:0], serial_out};
    rises++;
  end

  // accept watcher: pushes the expected transfer into the scoreboard
  always @(negedge sysclk) begin
    if (!poc && ld.load_valid && ld.load_ready) begin
      q.push_back('{word: ld.load_data, acc: cyc + 1});
      accs.push_back(cyc + 1);
      base = rises;
    end
  end

  // monitor: compares DUT outputs with the timing the scoreboard implies
  always @(negedge sysclk) begin
    bit exp_busy;
    bit exp_en;
    exp_t e;
    if (poc) begin
      q.delete();
      completed = 0;
    end else begin
      exp_busy = q.size() > 0 && cyc >= q[0].acc &&
                 cyc <= q[0].acc + W * P;
`ifdef I4003_LOADER_BLANK_EN
      exp_en = completed && !exp_busy;
`else
      exp_en = armed_m;
`endif
      chk("enable", enable, exp_en);
      chk("busy", busy, exp_busy);
      chk("ready", ld.load_ready, armed_m && !exp_busy);
      chk("done", done, q.size() > 0 && cyc == q[0].acc + W * P);
      if (!exp_busy) chk("so_idle", serial_out, 0);
      if (done) begin
        chk("done_q", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("chain", chain, e.word);
          chk("chip1", chain[W-1 -: 10], e.word[W-1 -: 10]);
          chk("rises", rises - base, W);
          chk("so_done", serial_out, 0);
        end
        completed = 1;
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit got;
    got = 0;
    @(posedge sysclk);
    #1;
    ld.load_valid = 1'b1;
    ld.load_data  = w;
    for (int i = 0; i < 4 * W * P && !got; i++) begin
      @(negedge sysclk);
      if (ld.load_ready) got = 1;
    end
    if (!got) chk("accept_timeout", ld.load_ready, 1);
    @(posedge sysclk);
    #1;
    ld.load_valid = 1'b0;
    ld.load_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while ((busy || q.size() > 0) && n < 4 * W * P);
    if (n >= 4 * W * P) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    int tgt;
    int n;
    ld.load_valid = 1'b0;
    ld.load_data  = '0;
    #1;
    chk("rst_cp", cp, 0);
    chk("rst_so", serial_out, 0);
    chk("rst_en", enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", ld.load_ready, 0);
    repeat (3) @(posedge sysclk);
    #2 poc = 1'b0;

    send(20'hABCDE);
    send(20'h55555);
    chk("b2b_gap", accs[1] - accs[0], W * P + 2);
    wait_idle();

    send(W'($urandom));
    n = 0;
    while (!done && n < 2 * W * P) begin
      @(negedge sysclk);
      n++;
    end
    chk("corner_done_seen", done, 1);
    #1 ld.load_valid = 1'b1;
    ld.load_data = W'($urandom);
    @(posedge sysclk);
    #1 ld.load_valid = 1'b0;
    repeat (4) @(negedge sysclk);
    chk("no_second_xfer", busy, 0);

    send(W'($urandom));
    tgt = accs[accs.size() - 1] + 4 * P + S;
    n = 0;
    while (cyc < tgt && n < 2 * W * P) begin
      @(negedge sysclk);
      n++;
    end
    chk("mid_cp_high", cp, 1);
    #1 poc = 1'b1;
    #1;
    chk("arst_cp", cp, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", ld.load_ready, 0);
    chk("arst_en", enable, 0);
    @(negedge sysclk);
    #2 poc = 1'b0;
    send(20'hFFFFF);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge sysclk);
      send(W'($urandom));
      if ($urandom_range(0, 1) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge sysclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i4003_loader.md
# i4003_loader

Serial load controller for the i4003 shift-register expander. It accepts a parallel word from a host-side requester (debug console, test sequencer or LED/keyboard scan logic) over a valid/ready handshake. It then sequences the i4003 `cp`, serial-data and `enable` pins so that the word lands in a chain of one or more cascaded i4003s. Everything is timed from `sysclk`, independent of the 4004 two-phase clock.

## Interface

Parameters:
- `CHAIN_LEN`, 1: number of cascaded i4003 chips; word width is `W = 10*CHAIN_LEN`.
- `SETUP_CYC`, 2: `sysclk` cycles serial data is stable before `cp` rises (≥1).
- `CP_HIGH_CYC`, 4: `sysclk` cycles `cp` is high (≥1).
- `CP_LOW_CYC`, 4: `sysclk` cycles `cp` is low after the high phase (≥1).

Ports:
- `sysclk`, in, 1: system clock. One clock for the whole block; all state changes on its rising edge.
- `poc`, in, 1: reset, asynchronous and active-high.
- `load_data`, in, W: word to load. Bit W-1 is shifted first and ends at the far end of the chain (last chip Q9).
- `load_valid`, in, 1: requester has a word.
- `load_ready`, out, 1: controller can accept a word.
- `cp`, out, 1: i4003 shift clock.
- `serial_out`, out, 1: drives i4003 serial data input.
- `enable`, out, 1: i4003 output enable.
- `busy`, out, 1: transfer in progress.
- `done`, out, 1: one-cycle pulse when a transfer completes.

## Operation

- **Reset values:** `load_ready`=0, `cp`=0, `serial_out`=0, `enable`=0, `busy`=0, `done`=0. State is IDLE and counters are 0.
- **FSM states:** IDLE, SETUP, CP_HI, CP_LO, DONE.
- **IDLE:**
  - `load_ready`=1 and `busy`=0.
  - A word is accepted on any edge where `load_valid & load_ready`.
  - On accept: `shreg` ← `load_data`, `bitcnt` ← W, go to SETUP.
- **SETUP:**
  - `serial_out` = `shreg[W-1]` and `cp`=0.
  - Stays SETUP_CYC cycles, then goes to CP_HI.
- **CP_HI:**
  - `cp`=1 and `serial_out` is held.
  - Stays CP_HIGH_CYC cycles, then goes to CP_LO.
- **CP_LO:**
  - `cp`=0 and `serial_out` is held.
  - On the last cycle: `shreg` shifts left by 1 (zero fill) and `bitcnt` decrements.
  - If the new `bitcnt` is 0, go to DONE; otherwise go to SETUP.
- **DONE:**
  - `done`=1 for exactly one cycle, `serial_out`=0, then go to IDLE.
- **`busy`:** 1 in SETUP, CP_HI, CP_LO and DONE.
- **Phase counter:** one down-counter, sized to `$clog2` of the largest phase length plus 1. It reloads on every state entry.
- **Bit counter:** `$clog2(W+1)` bits wide. It never wraps; W rising `cp` edges per word, exactly.
- **Backpressure:** `load_valid` asserted while busy is ignored. The word is taken only once IDLE is re-entered, and `load_data` need not be held before acceptance.
- **Capture rule:** `load_data` changing after acceptance has no effect.
- **Reset mid-transfer:** `poc` forces all outputs to their reset values immediately, without waiting for a clock edge. `cp` drops at once, the partial word is abandoned and no `done` is produced. The chip contents are undefined until the next full load.

## Timing

- Accept edge = cycle 0. SETUP begins at cycle 1.
- Bit k (k = 0..W-1):
  - `cp` rises at cycle `1 + k*P + SETUP_CYC`, where `P = SETUP_CYC+CP_HIGH_CYC+CP_LOW_CYC`.
  - `cp` falls CP_HIGH_CYC cycles later.
- `done` is high at cycle `1 + W*P`. `load_ready` returns to 1 at cycle `2 + W*P`.
- Minimum back-to-back word period is `W*P + 2` cycles.
- Data stability: `serial_out` is stable from SETUP_CYC cycles before each `cp` rise until CP_LOW_CYC cycles after its fall.

## Configuration

- **`I4003_LOADER_BLANK_EN` defined:**
  - `enable` is 0 from accept through DONE, so outputs are blanked while bits ripple.
  - `enable` goes 1 on the edge leaving DONE and stays 1 in IDLE.
  - `enable` reads 0 after reset until the first transfer completes.
- **Not defined:**
  - `enable` becomes 1 on the first `sysclk` edge after `poc` deasserts and stays 1.
  - Chip outputs show intermediate shift values during a transfer.

## Test plan

- **Basic load:** CHAIN_LEN=1, SETUP_CYC=1, CP_HIGH_CYC=2, CP_LOW_CYC=2, load 10'h2A5.
  - Expect exactly 10 `cp` rising edges.
  - `serial_out` sampled at each rise reads 1,0,1,0,1,0,0,1,0,1.
  - `done` pulses at cycle 51.
  - The i4003 model's parallel_out equals 10'h2A5.
- **Backpressure:** hold `load_valid` with 10'h155 during a 10'h2A5 transfer.
  - `load_ready`=0 throughout the transfer.
  - 10'h155 is accepted at cycle 52, with no gap beyond 1 idle cycle.
  - The model ends at 10'h155.
- **Cascade:** CHAIN_LEN=2, load 20'hABCDE.
  - Expect 20 `cp` edges.
  - Chip 1 holds 10'h2AF (upper 10 bits) and chip 0 holds 10'h0DE (lower 10 bits).
  - `done` pulses at `1+20*P`.
- **Reset mid-transfer:** assert `poc` mid-CP_HI on bit 4.
  - `cp` goes 0 immediately, asynchronously, and no `done` appears.
  - After release, `load_ready`=1 on the first edge.
  - A new 10'h3FF load completes correctly.
- **Blanking with `I4003_LOADER_BLANK_EN`:**
  - `enable` is 0 from the accept edge through DONE and 1 afterwards.
  - Without the macro, `enable` stays 1 the whole time after reset release.
- **Handshake corner:** assert `load_valid` for exactly one cycle in IDLE.
  - The word is accepted and `busy` rises next cycle.
  - `load_valid` pulses in DONE produce no second transfer.
